// File: rtl/data_memory_sync.sv
// Synchronous data memory with a registered read port and a clear-sweep engine (DATA_MEM_FWD_EN: write-first forwarding).
// Reads take 1 cycle. Busy stalls all accesses for DEPTH cycles while a clear sweep runs; there is no backpressure otherwise.
module data_memory_sync #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 5,
  parameter int              DEPTH    = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              En,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Rd_en,
  output logic [DATA_W-1:0] Data_out,
  output logic              Rd_valid,
  output logic              Busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_data;
  logic              addr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign addr_ok = ({1'b0, Address} < DEPTH_W);
  assign Busy    = (state_q == CLEAR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = Address;
    mem_wdata = Data_in;
    rd_fire   = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = INIT_VAL;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST) state_d = IDLE;
      end
      default: begin
        if (Clear) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          mem_we  = En && addr_ok;
          rd_fire = Rd_en;
        end
      end
    endcase
    // Reset wins over everything, including the sweep write.
    if (Reset) begin
      mem_we  = 1'b0;
      rd_fire = 1'b0;
    end
  end

  always_comb begin
    rd_data = addr_ok ? mem[Address] : '0;
`ifdef DATA_MEM_FWD_EN
    if (En && addr_ok) rd_data = Data_in;
`endif
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Data_out <= '0;
      Rd_valid <= 1'b0;
    end else begin
      Rd_valid <= rd_fire;
      if (rd_fire) Data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: a 32-word and a 20-word instance share one stimulus stream and are
// checked every cycle against a word-array reference model.
module tb_data_memory_sync;

`ifdef DATA_MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Clear = 1'b0;
  logic       En = 1'b0;
  logic [4:0] Address = '0;
  logic [7:0] Data_in = '0;
  logic       Rd_en = 1'b0;
  logic [7:0] dout [2];
  logic       rvalid [2];
  logic       busy [2];

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mm [2][32];
  int         sl [2];
  logic       rv [2];
  logic [7:0] dq [2];
  int         depth_of [2] = '{32, 20};

  always #5 Clk = ~Clk;

  data_memory_sync u_dut32 (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .En(En), .Address(Address),
    .Data_in(Data_in), .Rd_en(Rd_en), .Data_out(dout[0]), .Rd_valid(rvalid[0]), .Busy(busy[0])
  );

  data_memory_sync #(.DATA_W(8), .ADDR_W(5), .DEPTH(20)) u_dut20 (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .En(En), .Address(Address),
    .Data_in(Data_in), .Rd_en(Rd_en), .Data_out(dout[1]), .Rd_valid(rvalid[1]), .Busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the reference: what each memory must look like after this edge.
  task automatic model_step(input int k);
    int d;
    logic [7:0] old;
    d = depth_of[k];
    if (Reset) begin
      sl[k] = d;
      rv[k] = 1'b0;
      dq[k] = 8'h00;
    end else if (sl[k] > 0) begin
      mm[k][d - sl[k]] = 8'h00;
      sl[k] = sl[k] - 1;
      rv[k] = 1'b0;
    end else if (Clear) begin
      sl[k] = d;
      rv[k] = 1'b0;
    end else begin
      old   = (int'(Address) < d) ? mm[k][Address] : 8'h00;
      rv[k] = Rd_en;
      if (Rd_en) dq[k] = (FWD && En && int'(Address) < d) ? Data_in : old;
      if (En && int'(Address) < d) mm[k][Address] = Data_in;
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic e, input logic [4:0] a,
                     input logic [7:0] d, input logic re);
    Reset = r; Clear = c; En = e; Address = a; Data_in = d; Rd_en = re;
    @(posedge Clk);
    model_step(0);
    model_step(1);
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(sl[k] > 0));
      chk($sformatf("rd_valid%0d", k), 32'(rvalid[k]), 32'(rv[k]));
      chk($sformatf("data_out%0d", k), 32'(dout[k]), 32'(dq[k]));
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
  endtask

  initial begin
    int n0, n1;
    logic [7:0] exp_fwd;
    for (int k = 0; k < 2; k++) begin
      sl[k] = 0; rv[k] = 1'b0; dq[k] = 8'h00;
      for (int i = 0; i < 32; i++) mm[k][i] = 8'h00;
    end

    // Reset, then count Busy cycles after release
    @(negedge Clk);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    chk("reset_data_out", 32'(dout[0]), 32'h0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      idle();
    end
    chk("busy_len32", n0, 32);
    chk("busy_len20", n1, 20);
    for (int a = 0; a < 32; a++) cyc(1'b0, 1'b0, 1'b0, 5'(a), 8'h00, 1'b1);

    // Write then read, then idle hold
    cyc(1'b0, 1'b0, 1'b1, 5'd3, 8'hA5, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 5'd3, 8'h00, 1'b1);
    chk("rd_a5", 32'(dout[0]), 32'hA5);
    idle();
    chk("hold_a5_valid", 32'(rvalid[0]), 32'h0);
    chk("hold_a5_data", 32'(dout[0]), 32'hA5);

    // Same-address read and write in one cycle
    cyc(1'b0, 1'b0, 1'b1, 5'd7, 8'h11, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 5'd7, 8'h22, 1'b1);
    exp_fwd = FWD ? 8'h22 : 8'h11;
    chk("rw_same_addr", 32'(dout[0]), 32'(exp_fwd));
    cyc(1'b0, 1'b0, 1'b0, 5'd7, 8'h00, 1'b1);
    chk("reread_22", 32'(dout[0]), 32'h22);

    // Fill with FF, clear sweep with traffic ignored
    for (int a = 0; a < 32; a++) cyc(1'b0, 1'b0, 1'b1, 5'(a), 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 5'd4, 8'h33, 1'b1);
    n0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy[0]) n0++;
      cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          8'($urandom), 1'($urandom_range(0, 1)));
      if (busy[0]) chk("sweep_rd_valid", 32'(rvalid[0]), 32'h0);
    end
    chk("clear_busy_len", n0, 32);
    for (int a = 0; a < 32; a++) cyc(1'b0, 1'b0, 1'b0, 5'(a), 8'h00, 1'b1);

    // Reset partway through a sweep restarts it
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) idle();
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    n0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy[0]) n0++;
      idle();
    end
    chk("reset_restart_len", n0, 32);

    // Out-of-range address on the 20-word instance
    cyc(1'b0, 1'b0, 1'b1, 5'd19, 8'h3C, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 5'd25, 8'h5A, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 5'd25, 8'h00, 1'b1);
    chk("oob_rd_data", 32'(dout[1]), 32'h00);
    chk("oob_rd_valid", 32'(rvalid[1]), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 5'd19, 8'h00, 1'b1);
    chk("rd_19", 32'(dout[1]), 32'h3C);

    // Random traffic with occasional clear and reset
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
